chroma_ctrl_multi: RTL and testbench
====================================

# chroma_ctrl_multi

Parametrised colour/tone control register bank for the display path. Holds `NUM_CH` independent W-bit colour values (default: screen tone, letter colour, background colour), steps the channel chosen by `sel` from `UP`/`down` push-button levels with press-edge detection and hold-to-repeat, and clamps or wraps each channel within its own limits. Sits between the button front end and the pixel colour mux.

## Interface
- `NUM_CH`, 3, number of channels
- `W`, 8, bits per channel
- `RST_VAL`, 24'h0700A4, packed reset values; channel i at bits [i*W +: W]
- `MIN_VAL`, 24'h000049, packed per-channel lower limits
- `MAX_VAL`, 24'h0707FF, packed per-channel upper limits
- `WRAP`, 0, 0 = saturate at limits, 1 = wrap MAX->MIN and MIN->MAX
- `HOLD_CYC`, 4, cycles held before the first auto-repeat; 0 disables auto-repeat
- `REP_CYC`, 2, cycles between auto-repeats (>=1)

- `Clk`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sel`  in  $clog2(NUM_CH)  channel to modify
- `UP`  in  1  increment button level, synchronous to `Clk`
- `down`  in  1  decrement button level, synchronous to `Clk`
- `val`  out  NUM_CH*W  packed channel values, registered
- `upd`  out  1  one-cycle pulse: a channel value changed on this edge
- `lim`  out  1  selected channel currently equals its MIN or MAX (combinational from registers)

## Operation
- Reset: `val` = `RST_VAL`, `upd` = 0, button history and repeat counter cleared. Elaboration error unless MIN <= RST <= MAX per channel and `REP_CYC` >= 1.
- Step request: rising edge of `UP` (current 1, previous sample 0) gives +1; rising edge of `down` gives -1.
- Auto-repeat: while the same single button stays high and `sel` is unchanged, repeat steps fire at HOLD_CYC, HOLD_CYC+REP_CYC, HOLD_CYC+2*REP_CYC, ... cycles after the press edge.
- Both buttons high: no step; repeat counter cleared. Whichever is released later, the other produces no step until it is pressed again.
- `sel` changes while a button is held: repeat cancelled; no further step until release and a fresh press.
- `sel` >= NUM_CH: requests ignored; `lim` = 0.
- Arithmetic, W bits, unsigned. WRAP=0: +1 at MAX and -1 at MIN leave the value unchanged, with no `upd`. WRAP=1: MAX+1 -> MIN, MIN-1 -> MAX, with `upd`.
- Only the selected channel ever changes. At most one step per cycle.

## Timing
- Step latency: the new `val` is visible after the first `Clk` edge that samples the button at 1 with previous sample 0. `upd` is high for that same cycle.
- `lim` follows `val` with no extra delay.
- Button history register updates every cycle, including cycles where a step is ignored.
- Reset asserted mid-hold: everything returns to its reset value immediately. After release, a still-high button is not treated as a press until it goes low and high again, because the reset history is 1-filled.

## Structure
- Package `chroma_pkg`:
  - `step_e` enum (STEP_NONE, STEP_UP, STEP_DN)
  - function `chroma_step(val, dir, min, max, wrap)` returning the next value
  - default parameter constants for the three display channels
- Sub-module `chroma_btn_repeat`: edge detect, repeat counter (width $clog2(HOLD_CYC+REP_CYC+1)) and `sel`-change cancel. Outputs a one-cycle `step_e`.
- Top level: register bank, limit compare and `upd` generation.

## Test plan
- Reset, then press `UP` for 1 cycle with sel=0 -> ch0 0xA4->0xA5, `upd` pulses once, `lim`=0.
- sel=2 (value 0x07), press `UP` with WRAP=0 -> value stays 0x07, no `upd`, `lim`=1. With WRAP=1 -> 0x00, `upd`=1.
- sel=1, hold `UP` for 10 cycles (HOLD_CYC=4, REP_CYC=2) -> steps at cycles 0, 4, 6, 8; ch1 0->4; four `upd` pulses.
- Hold `UP`, raise `down` at cycle 2, drop both at cycle 5 -> only the cycle-0 step occurs.
- Hold `down` on sel=0, switch sel to 1 at cycle 3 -> ch0 decrements once; ch1 unchanged until release and re-press.
- Assert `reset` mid-hold, release with `UP` still high -> `val`=0x0700A4 and no step until `UP` goes low then high.

Source files
------------

// File: rtl/chroma_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chroma_pkg                                                           |
// | Shared step type, step arithmetic and default display channel set.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package chroma_pkg;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2
    } step_e;

    // Channel 0 = screen tone, 1 = letter colour, 2 = background colour
    localparam int          c_CHROMA_NUM_CH  = 3;
    localparam int          c_CHROMA_W       = 8;
    localparam logic [23:0] c_CHROMA_RST_VAL = 24'h0700A4;
    localparam logic [23:0] c_CHROMA_MIN_VAL = 24'h000049;
    localparam logic [23:0] c_CHROMA_MAX_VAL = 24'h0707FF;

    // Values are zero-extended channel values; callers truncate back to W bits.
    function automatic logic [31:0] chroma_step(
        input logic [31:0] val,
        input step_e       dir,
        input logic [31:0] min_v,
        input logic [31:0] max_v,
        input logic        wrap
    );
        logic [31:0] w_res;
        w_res = val;
        case (dir)
            STEP_UP: begin
                if (val >= max_v) w_res = wrap ? min_v : val;
                else              w_res = val + 32'd1;
            end
            STEP_DN: begin
                if (val <= min_v) w_res = wrap ? max_v : val;
                else              w_res = val - 32'd1;
            end
            default: w_res = val;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chroma_ctrl_multi_btn_repeat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chroma_btn_repeat                                                    |
// | Button edge detect, hold-to-repeat timing and select-change cancel.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module chroma_btn_repeat
    import chroma_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int SW       = 2,
    parameter int HOLD_CYC = 4,
    parameter int REP_CYC  = 2
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] i_sel,
    input  logic          i_up,
    input  logic          i_down,
    output step_e         o_step
);

    localparam int c_CNT_MAX = HOLD_CYC + REP_CYC;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    logic            r_up_q;
    logic            r_dn_q;
    logic [SW-1:0]   r_sel_q;
    logic            r_active;
    step_e           r_dir;
    logic [c_CW-1:0] r_cnt;

    logic w_sel_ok;
    logic w_only_up;
    logic w_only_dn;
    logic w_press_up;
    logic w_press_dn;
    logic w_hold;
    logic w_rep;

    assign w_sel_ok   = (32'(i_sel) < 32'(NUM_CH));
    assign w_only_up  = i_up & ~i_down;
    assign w_only_dn  = i_down & ~i_up;
    assign w_press_up = w_only_up & ~r_up_q & w_sel_ok;
    assign w_press_dn = w_only_dn & ~r_dn_q & w_sel_ok;
    assign w_hold     = r_active & w_sel_ok & (i_sel == r_sel_q) &
                        ((r_dir == STEP_UP) ? w_only_up : w_only_dn);
    // r_cnt equals cycles since the press until it reaches HOLD+REP, then cycles HOLD+1..HOLD+REP
    assign w_rep      = w_hold & (HOLD_CYC != 0) &
                        ((r_cnt == c_CW'(HOLD_CYC)) | (r_cnt == c_CW'(c_CNT_MAX)));

    always_comb begin
        o_step = STEP_NONE;
        if (w_press_up)      o_step = STEP_UP;
        else if (w_press_dn) o_step = STEP_DN;
        else if (w_rep)      o_step = r_dir;
    end

    // History resets 1-filled so a button still held through reset is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_q   <= 1'b1;
            r_dn_q   <= 1'b1;
            r_sel_q  <= '0;
            r_active <= 1'b0;
            r_dir    <= STEP_NONE;
            r_cnt    <= '0;
        end else begin
            r_up_q  <= i_up;
            r_dn_q  <= i_down;
            r_sel_q <= i_sel;
            if (w_press_up | w_press_dn) begin
                r_active <= 1'b1;
                r_dir    <= w_press_up ? STEP_UP : STEP_DN;
                r_cnt    <= c_CW'(1);
            end else if (w_hold) begin
                r_cnt <= (r_cnt == c_CW'(c_CNT_MAX)) ? c_CW'(HOLD_CYC + 1) : r_cnt + 1'b1;
            end else begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/chroma_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chroma_ctrl_multi                                                    |
// | Multi-channel colour/tone register bank stepped by up/down buttons.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module chroma_ctrl_multi
    import chroma_pkg::*;
#(
    parameter int                   NUM_CH   = c_CHROMA_NUM_CH,
    parameter int                   W        = c_CHROMA_W,
    parameter logic [NUM_CH*W-1:0]  RST_VAL  = c_CHROMA_RST_VAL,
    parameter logic [NUM_CH*W-1:0]  MIN_VAL  = c_CHROMA_MIN_VAL,
    parameter logic [NUM_CH*W-1:0]  MAX_VAL  = c_CHROMA_MAX_VAL,
    parameter int                   WRAP     = 0,
    parameter int                   HOLD_CYC = 4,
    parameter int                   REP_CYC  = 2
)(
    input  logic                                          Clk,
    input  logic                                          reset,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] sel,
    input  logic                                          UP,
    input  logic                                          down,
    output logic [NUM_CH*W-1:0]                           val,
    output logic                                          upd,
    output logic                                          lim
);

    localparam int c_SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    step_e        w_step;
    logic [W-1:0] r_val [NUM_CH];
    logic         r_upd;
    logic [W-1:0] w_cur;
    logic [W-1:0] w_min;
    logic [W-1:0] w_max;
    logic [W-1:0] w_next;
    logic         w_sel_ok;
    logic         w_change;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chk
        if ((MIN_VAL[gi*W +: W] > RST_VAL[gi*W +: W]) ||
            (RST_VAL[gi*W +: W] > MAX_VAL[gi*W +: W])) begin : g_bad_rst
            $error("chroma_ctrl_multi: reset value outside channel limits");
        end
    end
    if (REP_CYC < 1) begin : g_bad_rep
        $error("chroma_ctrl_multi: REP_CYC must be at least 1");
    end
    if (W > 32) begin : g_bad_w
        $error("chroma_ctrl_multi: W above 32 is not supported");
    end

    chroma_btn_repeat #(
        .NUM_CH   (NUM_CH),
        .SW       (c_SW),
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC)
    ) u_btn (
        .clk    (Clk),
        .rst    (reset),
        .i_sel  (sel),
        .i_up   (UP),
        .i_down (down),
        .o_step (w_step)
    );

    assign w_sel_ok = (32'(sel) < 32'(NUM_CH));

    always_comb begin
        w_cur = '0;
        w_min = '0;
        w_max = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == c_SW'(i)) begin
                w_cur = r_val[i];
                w_min = MIN_VAL[i*W +: W];
                w_max = MAX_VAL[i*W +: W];
            end
        end
    end

    assign w_next   = W'(chroma_step(32'(w_cur), w_step, 32'(w_min), 32'(w_max), WRAP != 0));
    // A saturated step leaves the value alone and must not pulse upd
    assign w_change = w_sel_ok & (w_step != STEP_NONE) & (w_next != w_cur);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_val[i] <= RST_VAL[i*W +: W];
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_change;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_change && (sel == c_SW'(i))) r_val[i] <= w_next;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign val[gi*W +: W] = r_val[gi];
    end

    assign upd = r_upd;
    assign lim = w_sel_ok & ((w_cur == w_min) | (w_cur == w_max));

endmodule
`default_nettype wire

// File: tb/tb_chroma_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chroma_ctrl_multi                                                 |
// | Saturating and wrapping instances against a behavioural model.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_chroma_ctrl_multi;

    localparam int c_HOLD = 4;
    localparam int c_REP  = 2;

    logic        Clk   = 1'b0;
    logic        reset = 1'b1;
    logic        UP    = 1'b0;
    logic        down  = 1'b0;
    logic [1:0]  sel   = 2'd0;
    logic [23:0] val0, val1;
    logic        upd0, upd1, lim0, lim1;

    int n_checks = 0;
    int n_errors = 0;

    int c_RST [3] = '{32'hA4, 32'h00, 32'h07};
    int c_MIN [3] = '{32'h49, 32'h00, 32'h00};
    int c_MAX [3] = '{32'hFF, 32'h07, 32'h07};

    // Model: per-instance values (0 = saturate, 1 = wrap) plus press/hold tracking
    int m_val [2][3];
    bit m_upd [2];
    bit m_pu, m_pd, m_hv;
    int m_hstart, m_hsel, m_hdir, m_cyc;

    always #5 Clk = ~Clk;

    chroma_ctrl_multi #(.WRAP(0)) u_dut0 (
        .Clk(Clk), .reset(reset), .sel(sel), .UP(UP), .down(down),
        .val(val0), .upd(upd0), .lim(lim0)
    );

    chroma_ctrl_multi #(.WRAP(1)) u_dut1 (
        .Clk(Clk), .reset(reset), .sel(sel), .UP(UP), .down(down),
        .val(val1), .upd(upd1), .lim(lim1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int ch = 0; ch < 3; ch++) m_val[w][ch] = c_RST[ch];
            m_upd[w] = 1'b0;
        end
        m_pu = 1'b1; m_pd = 1'b1; m_hv = 1'b0; m_cyc = 0;
    endfunction

    function automatic int next_val(input int v, input int dir, input int ch, input bit wrap);
        if (dir > 0) return (v == c_MAX[ch]) ? (wrap ? c_MIN[ch] : v) : v + 1;
        return (v == c_MIN[ch]) ? (wrap ? c_MAX[ch] : v) : v - 1;
    endfunction

    function automatic void model_step(input bit u, input bit d, input int s);
        int dir    = 0;
        bit single = u ^ d;
        int bdir   = u ? 1 : -1;
        int k;
        int nv;
        if (s < 3 && single && ((u && !m_pu) || (d && !m_pd))) begin
            dir = bdir; m_hv = 1'b1; m_hstart = m_cyc; m_hsel = s; m_hdir = bdir;
        end else if (m_hv && single && bdir == m_hdir && s == m_hsel) begin
            k = m_cyc - m_hstart;
            if (c_HOLD > 0 && k >= c_HOLD && (k - c_HOLD) % c_REP == 0) dir = m_hdir;
        end else begin
            m_hv = 1'b0;
        end
        for (int w = 0; w < 2; w++) begin
            m_upd[w] = 1'b0;
            if (dir != 0) begin
                nv = next_val(m_val[w][s], dir, s, w == 1);
                m_upd[w] = (nv != m_val[w][s]);
                m_val[w][s] = nv;
            end
        end
        m_pu = u; m_pd = d; m_cyc++;
    endfunction

    function automatic logic [23:0] pack(input int w);
        return {8'(m_val[w][2]), 8'(m_val[w][1]), 8'(m_val[w][0])};
    endfunction

    function automatic logic exp_lim(input int w);
        int s = int'(sel);
        if (s >= 3) return 1'b0;
        return (m_val[w][s] == c_MIN[s]) || (m_val[w][s] == c_MAX[s]);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".val0"}, 32'(val0), 32'(pack(0)));
        chk({tag, ".upd0"}, 32'(upd0), 32'(m_upd[0]));
        chk({tag, ".lim0"}, 32'(lim0), 32'(exp_lim(0)));
        chk({tag, ".val1"}, 32'(val1), 32'(pack(1)));
        chk({tag, ".upd1"}, 32'(upd1), 32'(m_upd[1]));
        chk({tag, ".lim1"}, 32'(lim1), 32'(exp_lim(1)));
    endtask

    task automatic do_cycle(input bit u, input bit d, input logic [1:0] s, input string tag);
        UP = u; down = d; sel = s;
        model_step(u, d, int'(s));
        @(posedge Clk); #1;
        check_outputs(tag);
    endtask

    initial begin
        int base;
        int hold_len;
        bit ru, rd;
        logic [1:0] rs;

        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("reset");
        chk("reset_val", 32'(val0), 32'h0700A4);
        reset = 1'b0;
        repeat (2) do_cycle(0, 0, 2'd0, "idle");

        // Single press on channel 0
        do_cycle(1, 0, 2'd0, "t1_press");
        chk("t1_ch0", 32'(val0[7:0]), 32'hA5);
        chk("t1_upd", 32'(upd0), 32'd1);
        do_cycle(0, 0, 2'd0, "t1_rel");

        // Channel 2 sits at its maximum: saturate vs wrap
        do_cycle(0, 0, 2'd2, "t2_idle");
        do_cycle(1, 0, 2'd2, "t2_press");
        chk("t2_sat", 32'(val0[23:16]), 32'h07);
        chk("t2_sat_lim", 32'(lim0), 32'd1);
        chk("t2_wrap", 32'(val1[23:16]), 32'h00);
        chk("t2_wrap_upd", 32'(upd1), 32'd1);
        do_cycle(0, 0, 2'd2, "t2_rel");

        // Hold-to-repeat on channel 1
        for (int i = 0; i < 10; i++) do_cycle(1, 0, 2'd1, "t3_hold");
        do_cycle(0, 0, 2'd1, "t3_rel");
        chk("t3_ch1", 32'(val0[15:8]), 32'd4);

        // Second button joins mid-hold
        do_cycle(0, 0, 2'd0, "t4_idle");
        base = m_val[0][0];
        do_cycle(1, 0, 2'd0, "t4_c0");
        do_cycle(1, 0, 2'd0, "t4_c1");
        for (int i = 2; i < 5; i++) do_cycle(1, 1, 2'd0, "t4_both");
        do_cycle(0, 0, 2'd0, "t4_rel");
        chk("t4_ch0", 32'(val0[7:0]), 32'(base + 1));

        // Select change while holding down
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 2'd0, "t5_hold0");
        for (int i = 3; i < 9; i++) do_cycle(0, 1, 2'd1, "t5_hold1");
        chk("t5_ch1_kept", 32'(val0[15:8]), 32'd4);
        do_cycle(0, 0, 2'd1, "t5_rel");
        do_cycle(0, 1, 2'd1, "t5_repress");
        chk("t5_ch1_dec", 32'(val0[15:8]), 32'd3);
        do_cycle(0, 0, 2'd1, "t5_rel2");

        // Out-of-range select
        do_cycle(1, 0, 2'd3, "t6_up");
        do_cycle(0, 0, 2'd3, "t6_rel");
        for (int i = 0; i < 6; i++) do_cycle(0, 1, 2'd3, "t6_dn");
        do_cycle(0, 0, 2'd3, "t6_rel2");

        // Reset asserted mid-hold, released with UP still high
        do_cycle(1, 0, 2'd0, "t7_press");
        do_cycle(1, 0, 2'd0, "t7_hold");
        reset = 1'b1;
        #1;
        model_reset();
        chk("t7_async_val0", 32'(val0), 32'h0700A4);
        chk("t7_async_val1", 32'(val1), 32'h0700A4);
        repeat (2) @(posedge Clk);
        #1;
        check_outputs("t7_in_reset");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) do_cycle(1, 0, 2'd0, "t7_still_high");
        chk("t7_no_step", 32'(val0[7:0]), 32'hA4);
        do_cycle(0, 0, 2'd0, "t7_low");
        do_cycle(1, 0, 2'd0, "t7_repress");
        chk("t7_step", 32'(val0[7:0]), 32'hA5);

        // Randomised button/select patterns
        for (int n = 0; n < 120; n++) begin
            ru = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) == 0) ? 1'b1 : ~ru;
            if ($urandom_range(0, 2) == 0) begin ru = 1'b0; rd = 1'b0; end
            rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : sel;
            hold_len = $urandom_range(1, 12);
            for (int c = 0; c < hold_len; c++) begin
                if ($urandom_range(0, 15) == 0) rs = 2'($urandom_range(0, 3));
                do_cycle(ru, rd, rs, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
